// File: rtl/mips_mc_sequencer.sv
// Multi-cycle MIPS control sequencer: FETCH/DECODE/EXEC/MEM/WB with a memory ready handshake.
// Optional retired-instruction counter enabled by defining MIPS_RETIRE_CNT_EN.
module mips_mc_sequencer #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_load,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StHalt   = 3'd6
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] FnAdd   = 6'b100000;
  localparam logic [5:0] FnSub   = 6'b100010;
  localparam logic [5:0] FnAnd   = 6'b100100;
  localparam logic [5:0] FnSlt   = 6'b101010;
  localparam logic [5:0] FnJr    = 6'b001000;

  state_e state_q, state_d;

  logic is_rtype, r_alu, is_jr, is_addi, is_lw, is_sw, is_beq, is_bne, legal;
  logic [1:0] r_alu_op;

  assign is_rtype = (opcode == OpRtype);
  assign r_alu    = is_rtype && ((funct == FnAdd) || (funct == FnSub) ||
                                 (funct == FnAnd) || (funct == FnSlt));
  assign is_jr    = is_rtype && (funct == FnJr);
  assign is_addi  = (opcode == OpAddi);
  assign is_lw    = (opcode == OpLw);
  assign is_sw    = (opcode == OpSw);
  assign is_beq   = (opcode == OpBeq);
  assign is_bne   = (opcode == OpBne);
  assign legal    = r_alu || is_jr || is_addi || is_lw || is_sw || is_beq || is_bne;

  always_comb begin
    case (funct)
      FnSub:   r_alu_op = 2'b01;
      FnAnd:   r_alu_op = 2'b10;
      FnSlt:   r_alu_op = 2'b11;
      default: r_alu_op = 2'b00;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_load      = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 2'b00;
    alu_src      = 1'b0;
    alu_op       = 2'b00;
    reg_write    = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    illegal      = 1'b0;

    case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_load  = 1'b1;
          pc_write = 1'b1;
          state_d  = StDecode;
        end
      end
      StDecode: state_d = legal ? StExec : StHalt;
      StExec: begin
        if (r_alu) begin
          alu_op  = r_alu_op;
          state_d = StWb;
        end else if (is_jr) begin
          pc_write = 1'b1;
          pc_src   = 2'b10;
          state_d  = StFetch;
        end else if (is_addi) begin
          alu_src = 1'b1;
          state_d = StWb;
        end else if (is_lw || is_sw) begin
          alu_src = 1'b1;
          state_d = StMem;
        end else if (is_beq || is_bne) begin
          alu_op   = 2'b01;
          pc_src   = 2'b01;
          pc_write = is_beq ? zero : !zero;
          state_d  = StFetch;
        end else begin
          state_d = StHalt;
        end
      end
      StMem: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = is_sw;
        if (mem_ready) state_d = is_sw ? StFetch : StWb;
      end
      StWb: begin
        reg_write  = 1'b1;
        reg_dst    = is_rtype;
        mem_to_reg = is_lw;
        state_d    = StFetch;
      end
      StHalt: illegal = 1'b1;
      default: state_d = StIdle;
    endcase

    // Outputs are held low combinationally for the whole reset pulse.
    if (reset) begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_load      = 1'b0;
      pc_write     = 1'b0;
      pc_src       = 2'b00;
      alu_src      = 1'b0;
      alu_op       = 2'b00;
      reg_write    = 1'b0;
      reg_dst      = 1'b0;
      mem_to_reg   = 1'b0;
      illegal      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  assign state = reset ? 3'd0 : state_q;

`ifdef MIPS_RETIRE_CNT_EN
  logic [CNT_W-1:0] retired_q;
  logic             retire;

  // One count per completed instruction: any return to FETCH except from IDLE.
  assign retire = (state_d == StFetch) &&
                  ((state_q == StExec) || (state_q == StMem) || (state_q == StWb));

  always_ff @(posedge clk) begin
    if (reset)       retired_q <= '0;
    else if (retire) retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign retired = reset ? '0 : retired_q;
`else
  assign retired = '0;
`endif

endmodule

// File: tb/tb_mips_mc_sequencer.sv
// Scoreboard bench for mips_mc_sequencer: random instruction stream checked per instruction
// against an instruction-level reference model, plus directed reset and illegal-halt checks.
module tb_mips_mc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode, funct;
  logic        zero, mem_ready;
  logic        mem_req, mem_we, mem_addr_sel, ir_load, pc_write;
  logic [1:0]  pc_src, alu_op;
  logic        alu_src, reg_write, reg_dst, mem_to_reg, illegal;
  logic [2:0]  state;
  logic [31:0] retired;

  mips_mc_sequencer #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .ir_load(ir_load), .pc_write(pc_write), .pc_src(pc_src), .alu_src(alu_src),
    .alu_op(alu_op), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .illegal(illegal), .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  // Per-instruction summary, measured from one FETCH entry to the next.
  typedef struct {
    string nm;
    int len, n_rw, dst, m2r, n_pcw, pcsrc, asrc, aop, n_fetch, n_dr, n_dw, n_ir, fpc;
  } rec_t;

  rec_t        exp_q[$];
  int          n_chk = 0, n_fail = 0, n_recs = 0;
  bit          drv_en = 0, mon_en = 0, want_illegal = 0, drew_illegal = 0;
  logic [31:0] exp_ret = '0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int outs();
    return int'({mem_req, mem_we, mem_addr_sel, ir_load, pc_write, pc_src, alu_src, alu_op,
                 reg_write, reg_dst, mem_to_reg, illegal, state, |retired});
  endfunction

  // cls: 0 ADD 1 SUB 2 AND 3 SLT 4 JR 5 ADDI 6 LW 7 SW 8 BEQ 9 BNE
  function automatic rec_t model(int cls, int z, int fw, int mw);
    rec_t r = '{default: 0};
    r.n_ir = 1; r.fpc = 1; r.n_fetch = fw + 1;
    case (cls)
      0, 1, 2, 3: begin r.nm = "RALU"; r.len = 4 + fw; r.n_rw = 1; r.dst = 1; r.aop = cls; end
      4: begin r.nm = "JR"; r.len = 3 + fw; r.n_pcw = 1; r.pcsrc = 2; end
      5: begin r.nm = "ADDI"; r.len = 4 + fw; r.n_rw = 1; r.asrc = 1; end
      6: begin
        r.nm = "LW"; r.len = 5 + fw + mw; r.n_rw = 1; r.m2r = 1; r.asrc = 1; r.n_dr = mw + 1;
      end
      7: begin r.nm = "SW"; r.len = 4 + fw + mw; r.asrc = 1; r.n_dw = mw + 1; end
      default: begin
        r.nm = (cls == 8) ? "BEQ" : "BNE"; r.len = 3 + fw; r.aop = 1;
        if ((cls == 8) ? (z != 0) : (z == 0)) begin r.n_pcw = 1; r.pcsrc = 1; end
      end
    endcase
    return r;
  endfunction

  // Driver: reacts to FETCH/MEM entry to pace mem_ready; randomises it elsewhere.
  int     d_fw, d_mw, fcnt, mcnt;
  logic [2:0] d_prev = 3'd0;
  always @(posedge clk) begin
    #1;
    if (drv_en && !reset) begin
      if (state == 3'd1) begin
        if (d_prev != 3'd1) begin
          d_fw = $urandom_range(0, 2);
          d_mw = $urandom_range(0, 3);
          if (want_illegal && !drew_illegal) begin
            opcode = 6'b111111; funct = 6'($urandom); drew_illegal = 1;
          end else begin
            int cls;
            cls  = $urandom_range(0, 9);
            zero = 1'($urandom_range(0, 1));
            funct = 6'($urandom);
            case (cls)
              0: begin opcode = 6'b000000; funct = 6'b100000; end
              1: begin opcode = 6'b000000; funct = 6'b100010; end
              2: begin opcode = 6'b000000; funct = 6'b100100; end
              3: begin opcode = 6'b000000; funct = 6'b101010; end
              4: begin opcode = 6'b000000; funct = 6'b001000; end
              5: opcode = 6'b001000;
              6: opcode = 6'b100011;
              7: opcode = 6'b101011;
              8: opcode = 6'b000100;
              default: opcode = 6'b000101;
            endcase
            exp_q.push_back(model(cls, int'(zero), d_fw, d_mw));
          end
          fcnt = 0;
        end
        mem_ready = (fcnt == d_fw);
        fcnt++;
      end else if (state == 3'd4) begin
        if (d_prev != 3'd4) mcnt = 0;
        mem_ready = (mcnt == d_mw);
        mcnt++;
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      d_prev = state;
    end
  end

  // Monitor: accumulates observed behaviour and scores it at each FETCH entry.
  rec_t       acc, m_e;
  bit         m_have = 0;
  logic [2:0] m_prev = 3'd0;
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (state == 3'd1 && m_prev != 3'd1) begin
        if (m_have) begin
          if (exp_q.size() == 0) chk("scoreboard_underflow", 1, 0);
          else begin
            m_e = exp_q.pop_front();
            chk({m_e.nm, ".len"},     acc.len,     m_e.len);
            chk({m_e.nm, ".n_rw"},    acc.n_rw,    m_e.n_rw);
            chk({m_e.nm, ".reg_dst"}, acc.dst,     m_e.dst);
            chk({m_e.nm, ".m2r"},     acc.m2r,     m_e.m2r);
            chk({m_e.nm, ".n_pcw"},   acc.n_pcw,   m_e.n_pcw);
            chk({m_e.nm, ".pc_src"},  acc.pcsrc,   m_e.pcsrc);
            chk({m_e.nm, ".alu_src"}, acc.asrc,    m_e.asrc);
            chk({m_e.nm, ".alu_op"},  acc.aop,     m_e.aop);
            chk({m_e.nm, ".n_fetch"}, acc.n_fetch, m_e.n_fetch);
            chk({m_e.nm, ".n_dread"}, acc.n_dr,    m_e.n_dr);
            chk({m_e.nm, ".n_dwrite"}, acc.n_dw,   m_e.n_dw);
            chk({m_e.nm, ".n_ir"},    acc.n_ir,    m_e.n_ir);
            chk({m_e.nm, ".fetch_pc"}, acc.fpc,    m_e.fpc);
            exp_ret = exp_ret + 32'd1;
`ifdef MIPS_RETIRE_CNT_EN
            chk("retired", int'(retired), int'(exp_ret));
`else
            chk("retired_tied", int'(retired), 0);
`endif
            n_recs++;
          end
        end
        acc = '{default: 0};
        m_have = 1;
      end
      if (m_have) begin
        acc.len++;
        if (reg_write) begin acc.n_rw++; acc.dst = int'(reg_dst); acc.m2r = int'(mem_to_reg); end
        if (pc_write && !ir_load) begin acc.n_pcw++; acc.pcsrc = int'(pc_src); end
        if (state == 3'd3) begin acc.asrc = int'(alu_src); acc.aop = int'(alu_op); end
        if (mem_req && !mem_addr_sel) acc.n_fetch++;
        if (mem_req && mem_addr_sel && !mem_we) acc.n_dr++;
        if (mem_req && mem_addr_sel && mem_we) acc.n_dw++;
        if (ir_load) begin acc.n_ir++; acc.fpc = int'(pc_write && pc_src == 2'b00); end
      end
      chk("one_writer", int'(reg_write && mem_req && mem_we), 0);
    end
    m_prev = state;
  end

  initial begin
    int cyc;
    reset = 1'b1; mem_ready = 1'b1; opcode = 6'b100011; funct = 6'd0; zero = 1'b0;
    repeat (2) begin @(negedge clk); chk("reset_outs", outs(), 0); end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk); chk("idle_outs", outs(), 0);
    @(negedge clk);
    chk("fetch_state", int'(state), 1);
    chk("fetch_strobes", int'({ir_load, pc_write, pc_src, mem_req}), 'b11001);
    @(posedge clk); #1 mem_ready = 1'b0;
    @(negedge clk); chk("decode_state", int'(state), 2);
    @(negedge clk); chk("lw_exec", int'({state, alu_src, alu_op}), 'b011100);
    @(negedge clk); chk("lw_mem", int'({state, mem_req, mem_addr_sel, mem_we}), 'b100110);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk); chk("reset_mid_mem", outs(), 0);
    @(negedge clk); chk("reset_mid_mem2", outs(), 0);
    @(posedge clk); #1 reset = 1'b0; drv_en = 1; mon_en = 1;
`ifdef MIPS_RETIRE_CNT_EN
    force dut.retired_q = '1;
    exp_ret = '1;
`endif
    @(negedge clk); chk("post_reset_idle", int'(state), 0);
`ifdef MIPS_RETIRE_CNT_EN
    @(posedge clk); #1 release dut.retired_q;
`endif
    @(negedge clk); chk("post_reset_fetch", int'(state), 1);

    cyc = 0;
    while (n_recs < 300 && cyc < 20000) begin @(negedge clk); cyc++; end
    chk("random_phase_done", int'(n_recs >= 300), 1);

    want_illegal = 1;
    cyc = 0;
    while (state != 3'd6 && cyc < 200) begin @(negedge clk); cyc++; end
    chk("reach_halt", int'(state), 6);
    mon_en = 0;
    repeat (20) begin
      @(negedge clk);
      chk("halt_sticky", int'({illegal, state, mem_req, pc_write, reg_write, ir_load}),
          'b1110_0000);
    end
    chk("queue_drained", exp_q.size(), 0);
    @(posedge clk); #1 drv_en = 0; reset = 1'b1;
    @(negedge clk); chk("halt_reset_outs", outs(), 0);
    @(posedge clk); #1 reset = 1'b0; mem_ready = 1'b0;
    @(negedge clk); chk("halt_cleared", int'({illegal, state}), 0);
    @(negedge clk); chk("restart_fetch", int'({illegal, state, mem_req}), 'b00011);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
